// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns byte/half/word requests into word-wide, big-endian memory
// transactions, with read-modify-write for sub-word stores. Optional macro: LSU_FORCE_ALIGN_EN.
module lsu_mem_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_unsigned,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_resp_valid,
    output logic [DW-1:0] o_resp_rdata,
    output logic          o_resp_err,
    output logic          o_mem_en,
    output logic          o_mem_wr,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_ERR,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_lane;
    logic [DW-1:0] r_wdata;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [DW-1:0] r_resp_rdata;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    logic          w_misaligned;
    logic          w_err;
    logic [AW-1:0] w_addr;

    assign w_misaligned = ((i_req_size == 2'd1) && i_req_addr[0]) ||
                          ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'b00));

`ifdef LSU_FORCE_ALIGN_EN
    // Misalignment is repaired by rounding the address down to the access size.
    assign w_err  = (i_req_size == 2'd3);
    assign w_addr = (i_req_size == 2'd1) ? {i_req_addr[AW-1:1], 1'b0} :
                    (i_req_size == 2'd2) ? {i_req_addr[AW-1:2], 2'b00} : i_req_addr;
`else
    assign w_err  = (i_req_size == 2'd3) || w_misaligned;
    assign w_addr = i_req_addr;
`endif

    // Lane 0 is the most significant byte of the word (big-endian).
    function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] lane,
                                                   input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [DW-1:0] res;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[15:0] : word[31:16];
        case (size)
            2'd0:    res = {{24{~uns & b[7]}}, b};
            2'd1:    res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                  input logic [DW-1:0] wd,
                                                  input logic [1:0] size,
                                                  input logic [1:0] lane);
        logic [DW-1:0] res;
        res = word;
        if (size == 2'd0) begin
            case (lane)
                2'd0:    res[31:24] = wd[7:0];
                2'd1:    res[23:16] = wd[7:0];
                2'd2:    res[15:8]  = wd[7:0];
                default: res[7:0]   = wd[7:0];
            endcase
        end else if (size == 2'd1) begin
            if (lane[1]) res[15:0]  = wd[15:0];
            else         res[31:16] = wd[15:0];
        end else begin
            res = wd;
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'd0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_en     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_lane     <= w_addr[1:0];
                        r_wdata    <= i_req_wdata;
                        if (w_err) begin
                            r_state <= S_ERR;
                        end else begin
                            // Memory strobes are launched here so they are live during the next state.
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= {w_addr[AW-1:2], 2'b00};
                            if (!i_req_we) begin
                                r_mem_wr <= 1'b0;
                                r_state  <= S_LOAD;
                            end else if (i_req_size == 2'd2) begin
                                r_mem_wr    <= 1'b1;
                                r_mem_wdata <= i_req_wdata;
                                r_state     <= S_WRITE;
                            end else begin
                                r_mem_wr <= 1'b0;
                                r_state  <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_mem_en     <= 1'b0;
                    r_resp_rdata <= load_extract(i_mem_rdata, r_size, r_lane, r_unsigned);
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RMW_RD: begin
                    r_mem_wr    <= 1'b1;
                    r_mem_wdata <= store_merge(i_mem_rdata, r_wdata, r_size, r_lane);
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_mem_en     <= 1'b0;
                    r_mem_wr     <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_ERR: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = r_resp_rdata;
    assign o_mem_en     = r_mem_en;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-array reference model and a 64-word memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] phys_mem [0:63];
    logic [31:0] init_mem [0:63];
    logic [31:0] ref_mem  [0:63];
    logic        init_go;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_resp_valid  (resp_valid),
        .o_resp_rdata  (resp_rdata),
        .o_resp_err    (resp_err),
        .o_mem_en      (mem_en),
        .o_mem_wr      (mem_wr),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata)
    );

    assign mem_rdata = phys_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (init_go) begin
            for (int i = 0; i < 64; i++) phys_mem[i] <= init_mem[i];
        end else if (mem_en && mem_wr) begin
            phys_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, compare every observable against the reference model.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit uns,
                          input bit [31:0] a, input bit [31:0] wd,
                          output logic [31:0] got_rdata, output logic got_err);
        bit          err;
        int          n, k, lat, en_c, wr_c, exp_lat, exp_en, exp_wr;
        bit [31:0]   ea, w, expd, bval;
        logic [31:0] seen_addr;

        n   = 1 << sz;
        err = (sz == 2'd3);
        ea  = a;
`ifdef LSU_FORCE_ALIGN_EN
        if (!err) ea = a - (a % n);
`else
        if (!err && (a % n) != 0) err = 1'b1;
`endif
        expd = 0; exp_lat = 2; exp_en = 0; exp_wr = 0;
        if (!err) begin
            w = ref_mem[ea[7:2]];
            if (!we) begin
                for (int i = 0; i < n; i++) begin
                    k    = int'(ea % 4) + i;
                    expd = (expd << 8) | ((w >> (8 * (3 - k))) & 32'hFF);
                end
                if (!uns && n < 4 && expd[8*n-1]) expd = expd | (32'hFFFF_FFFF << (8 * n));
                exp_en = 1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    k    = int'(ea % 4) + i;
                    bval = (wd >> (8 * (n - 1 - i))) & 32'hFF;
                    w    = (w & ~(32'hFF << (8 * (3 - k)))) | (bval << (8 * (3 - k)));
                end
                ref_mem[ea[7:2]] = w;
                exp_en  = (n == 4) ? 1 : 2;
                exp_wr  = 1;
                exp_lat = (n == 4) ? 2 : 3;
            end
        end

        @(negedge clk);
        chk("ready", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; en_c = 0; wr_c = 0; seen_addr = '0;
        got_rdata = '0; got_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_c++;
                seen_addr = mem_addr;
            end
            if (mem_en && mem_wr) wr_c++;
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
                break;
            end
        end
        $display("req we=%0d sz=%0d u=%0d a=%h wd=%h -> rdata=%h err=%0d lat=%0d",
                 we, sz, uns, a, wd, got_rdata, got_err, lat);
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'd0, got_err}, {31'd0, err});
        chk("resp_rdata", got_rdata, expd);
        chk("mem_en_cycles", en_c, exp_en);
        chk("write_cycles", wr_c, exp_wr);
        if (exp_en > 0) chk("mem_addr", seen_addr, {ea[31:2], 2'b00});
        @(negedge clk);
        chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
    endtask

    logic [31:0] g_rd;
    logic        g_err;
    int          seen;

    initial begin
        rst = 1'b1; init_go = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[4]  = 32'h8081_7F01;
        init_mem[8]  = 32'h0;
        init_mem[12] = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];

        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        init_go = 1'b0;
        rst = 1'b0;

        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, g_rd, g_err);
        chk("tp_lb", g_rd, 32'hFFFF_FF81);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, g_rd, g_err);
        chk("tp_lbu", g_rd, 32'h0000_0081);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, g_rd, g_err);
        chk("tp_lh", g_rd, 32'h0000_7F01);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, g_rd, g_err);
        chk("tp_lw", g_rd, 32'h8081_7F01);
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF, g_rd, g_err);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, g_rd, g_err);
        chk("tp_sw_lw", g_rd, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h55, g_rd, g_err);
        do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h1234, g_rd, g_err);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, g_rd, g_err);
        chk("tp_rmw_word", g_rd, 32'h1234_55EF);
        do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, g_rd, g_err);
`ifdef LSU_FORCE_ALIGN_EN
        chk("tp_lw_misalign", g_rd, 32'h8081_7F01);
`else
        chk("tp_lw_misalign", {31'd0, g_err}, 32'd1);
`endif
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, g_rd, g_err);
        chk("tp_size3", {31'd0, g_err}, 32'd1);
        do_req(1'b1, 2'd1, 1'b0, 32'h15, 32'hABCD, g_rd, g_err);

        // Reset lands while the word store is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_live", {31'd0, mem_en & mem_wr}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_mid_en_drop", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        $display("reset during SW 0x30: resp pulses=%0d ready=%0d word=%h", seen, req_ready, phys_mem[12]);
        chk("rst_mid_no_resp", seen, 0);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_word", phys_mem[12], 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, g_rd, g_err);
        chk("rst_mid_lw", g_rd, 32'd0);

        for (int t = 0; t < 300; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
                   $urandom, g_rd, g_err);
        end

        for (int i = 0; i < 64; i++) chk("final_mem", phys_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the CPU memory pipeline stage and the word-wide, big-endian data memory.
- Memory-side contract:
  - Writes commit on the clk edge when mem_en=1 and mem_wr=1.
  - Read data is combinational when mem_en=1 and mem_wr=0.
  - The memory forces word alignment.
- The block turns byte/halfword/word loads and stores into word transactions:
  - Loads: extracts the lane, then sign- or zero-extends.
  - Sub-word stores: performs a read-modify-write.

Parameters:
- AW, 32, address width of req_addr and mem_addr.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=invalid.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned or invalid size.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  AW  word-aligned address, low 2 bits always 0.
- mem_wdata  out  DW  merged write word.
- mem_rdata  in  DW  memory read data, combinational.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - req_ready=1 while in IDLE.
- Handshake:
  - Accept when req_valid && req_ready at a clk edge; all req_* fields are latched.
  - No backpressure on the response; the requester must take resp_valid when it pulses.
- Alignment check at accept:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - size=3 is always an error.
- States and transitions:
  - IDLE: on accept, go to ERR if there is an error; else LOAD for a load; else WRITE for a word store; else RMW_RD for a sub-word store.
  - LOAD: mem_en=1, mem_wr=0, mem_addr={addr[AW-1:2],2'b00}. Capture the extracted and extended mem_rdata, then go to RESP.
  - RMW_RD: same read as LOAD. Merge the store bytes into the captured word, then go to WRITE.
  - WRITE: mem_en=1, mem_wr=1, mem_wdata=merged word (req_wdata for a word store), then go to RESP.
  - ERR: no memory access. Set resp_err, then go to RESP.
  - RESP: resp_valid=1 for exactly 1 cycle, then go to IDLE.
  - mem_en=0 in every state other than LOAD, RMW_RD and WRITE.
- Latency, from the accept edge to the resp_valid cycle:
  - Error: 2 cycles.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Big-endian lanes:
  - Byte addr[1:0]=0,1,2,3 maps to bits [31:24], [23:16], [15:8], [7:0].
  - Half addr[1]=0 maps to [31:16]; addr[1]=1 maps to [15:0].
- Extension: signed loads replicate the lane MSB; unsigned loads zero-fill.
- Store merge: only the addressed lane(s) are replaced; the other bytes keep their read value.
- Reset mid-operation:
  - State returns to IDLE and mem_en drops immediately.
  - A pending WRITE not yet clocked is discarded.
  - No resp_valid is produced.
- resp_rdata and resp_err hold their last value outside RESP. The consumer qualifies them with resp_valid.

Optional Feature:
- Macro: LSU_FORCE_ALIGN_EN.
- Defined:
  - Misaligned half/word requests are not errors.
  - The address is aligned down: half clears addr[0]; word clears addr[1:0].
  - The request then proceeds normally.
  - size=3 is still an error.
- Undefined: misalignment gives resp_err=1 with no memory access, as above.

Test Plan:
- Memory word @0x10 = 0x8081_7F01. Loads from 0x11:
  - LB gives 0xFFFF_FF81.
  - LBU gives 0x0000_0081.
  - LH 0x12 gives 0x0000_7F01.
  - LW 0x10 gives 0x8081_7F01.
  - Each response arrives 2 cycles after accept.
- SW 0x20 with 0xDEAD_BEEF: one write cycle with mem_wdata=0xDEAD_BEEF; resp_valid 2 cycles after accept. A following LW 0x20 returns 0xDEAD_BEEF.
- Word @0x20 = 0xDEAD_BEEF. SB 0x22 with data 0x55, then SH 0x20 with data 0x1234. Word becomes 0x1234_55EF. Each store shows a read cycle, then a write cycle, then resp_valid at +3.
- LW 0x13, without the macro: resp_err=1 and resp_rdata=0 at +2, with mem_en never asserted. With LSU_FORCE_ALIGN_EN: reads 0x10 and returns its word.
- Req size=3: resp_err=1 with and without the macro.
- Assert rst during WRITE of SW 0x30 with data 0x1111_1111, old word 0: the word stays 0, no resp_valid, and req_ready=1 after release. A new LW 0x30 returns 0.
